// File: rtl/execution_stage.sv
// EX stage of the 5-stage RV32I pipeline: operand select, ALU, branch/jump
// resolution, and the EX/MEM pipeline register with stall and bubble insertion.
module execution_stage (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL_EXECUTION_STAGE,
  input  logic        CLEAR_EXECUTION_STAGE,
  input  logic [31:0] PC_IN,
  input  logic [4:0]  RD_ADDRESS_IN,
  input  logic [31:0] RS1_DATA,
  input  logic [31:0] RS2_DATA,
  input  logic [31:0] IMM_DATA,
  input  logic [4:0]  ALU_INSTRUCTION,
  input  logic        ALU_INPUT_1_SELECT,
  input  logic        ALU_INPUT_2_SELECT,
  input  logic [2:0]  DATA_CACHE_LOAD_IN,
  input  logic [1:0]  DATA_CACHE_STORE_IN,
  input  logic        WRITE_BACK_MUX_SELECT_IN,
  input  logic        RD_WRITE_ENABLE_IN,
  output logic [4:0]  RD_ADDRESS_OUT,
  output logic [31:0] ALU_OUT,
  output logic        BRANCH_TAKEN,
  output logic [2:0]  DATA_CACHE_LOAD_OUT,
  output logic [1:0]  DATA_CACHE_STORE_OUT,
  output logic [31:0] DATA_CACHE_STORE_DATA,
  output logic        WRITE_BACK_MUX_SELECT_OUT,
  output logic        RD_WRITE_ENABLE_OUT
);

  localparam int DATA_W = 32;

  localparam logic [4:0] OP_NOP    = 5'd0;
  localparam logic [4:0] OP_ADD    = 5'd1;
  localparam logic [4:0] OP_SUB    = 5'd2;
  localparam logic [4:0] OP_SLL    = 5'd3;
  localparam logic [4:0] OP_SLT    = 5'd4;
  localparam logic [4:0] OP_SLTU   = 5'd5;
  localparam logic [4:0] OP_XOR    = 5'd6;
  localparam logic [4:0] OP_SRL    = 5'd7;
  localparam logic [4:0] OP_SRA    = 5'd8;
  localparam logic [4:0] OP_OR     = 5'd9;
  localparam logic [4:0] OP_AND    = 5'd10;
  localparam logic [4:0] OP_BEQ    = 5'd11;
  localparam logic [4:0] OP_BNE    = 5'd12;
  localparam logic [4:0] OP_BLT    = 5'd13;
  localparam logic [4:0] OP_BGE    = 5'd14;
  localparam logic [4:0] OP_BLTU   = 5'd15;
  localparam logic [4:0] OP_BGEU   = 5'd16;
  localparam logic [4:0] OP_JUMP   = 5'd17;
  localparam logic [4:0] OP_PASS_B = 5'd18;

  function automatic logic [DATA_W-1:0] alu_calc(input logic [4:0] op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;
    logic [DATA_W-1:0]        sum;
    logic [4:0]               sh;
    a_s = a;
    b_s = b;
    sum = a + b;
    sh  = b[4:0];
    case (op)
      OP_ADD:    alu_calc = sum;
      OP_SUB:    alu_calc = a - b;
      OP_SLL:    alu_calc = a << sh;
      OP_SLT:    alu_calc = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
      OP_SLTU:   alu_calc = {{(DATA_W-1){1'b0}}, (a < b)};
      OP_XOR:    alu_calc = a ^ b;
      OP_SRL:    alu_calc = a >> sh;
      OP_SRA:    alu_calc = a_s >>> sh;
      OP_OR:     alu_calc = a | b;
      OP_AND:    alu_calc = a & b;
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU:
                 alu_calc = sum;
      OP_JUMP:   alu_calc = {sum[DATA_W-1:1], 1'b0};
      OP_PASS_B: alu_calc = b;
      default:   alu_calc = '0;
    endcase
  endfunction

  // Branch conditions always look at the register operands, never the muxed ALU inputs.
  function automatic logic branch_calc(input logic [4:0] op,
                                       input logic [DATA_W-1:0] rs1,
                                       input logic [DATA_W-1:0] rs2);
    logic signed [DATA_W-1:0] rs1_s;
    logic signed [DATA_W-1:0] rs2_s;
    rs1_s = rs1;
    rs2_s = rs2;
    case (op)
      OP_BEQ:  branch_calc = (rs1 == rs2);
      OP_BNE:  branch_calc = (rs1 != rs2);
      OP_BLT:  branch_calc = (rs1_s < rs2_s);
      OP_BGE:  branch_calc = (rs1_s >= rs2_s);
      OP_BLTU: branch_calc = (rs1 < rs2);
      OP_BGEU: branch_calc = (rs1 >= rs2);
      OP_JUMP: branch_calc = 1'b1;
      default: branch_calc = 1'b0;
    endcase
  endfunction

  logic [DATA_W-1:0] operand_a_p0;
  logic [DATA_W-1:0] operand_b_p0;
  logic [DATA_W-1:0] alu_result_p0;
  logic              branch_p0;

  assign operand_a_p0  = ALU_INPUT_1_SELECT ? PC_IN : RS1_DATA;
  assign operand_b_p0  = ALU_INPUT_2_SELECT ? IMM_DATA : RS2_DATA;
  assign alu_result_p0 = alu_calc(ALU_INSTRUCTION, operand_a_p0, operand_b_p0);
  assign branch_p0     = branch_calc(ALU_INSTRUCTION, RS1_DATA, RS2_DATA);

  // ---- EX/MEM boundary ----
  logic [4:0]        rd_address_p1;
  logic [DATA_W-1:0] alu_out_p1;
  logic              branch_taken_p1;
  logic [2:0]        load_p1;
  logic [1:0]        store_p1;
  logic [DATA_W-1:0] store_data_p1;
  logic              wb_select_p1;
  logic              rd_write_enable_p1;

  always_ff @(posedge CLK) begin
    if (RST || CLEAR_EXECUTION_STAGE) begin
      rd_address_p1      <= '0;
      alu_out_p1         <= '0;
      branch_taken_p1    <= 1'b0;
      load_p1            <= '0;
      store_p1           <= '0;
      store_data_p1      <= '0;
      wb_select_p1       <= 1'b0;
      rd_write_enable_p1 <= 1'b0;
    end else if (!STALL_EXECUTION_STAGE) begin
      rd_address_p1      <= RD_ADDRESS_IN;
      alu_out_p1         <= alu_result_p0;
      branch_taken_p1    <= branch_p0;
      load_p1            <= DATA_CACHE_LOAD_IN;
      store_p1           <= DATA_CACHE_STORE_IN;
      store_data_p1      <= RS2_DATA;
      wb_select_p1       <= WRITE_BACK_MUX_SELECT_IN;
      rd_write_enable_p1 <= RD_WRITE_ENABLE_IN;
    end
  end

  assign RD_ADDRESS_OUT            = rd_address_p1;
  assign ALU_OUT                   = alu_out_p1;
  assign BRANCH_TAKEN              = branch_taken_p1;
  assign DATA_CACHE_LOAD_OUT       = load_p1;
  assign DATA_CACHE_STORE_OUT      = store_p1;
  assign DATA_CACHE_STORE_DATA     = store_data_p1;
  assign WRITE_BACK_MUX_SELECT_OUT = wb_select_p1;
  assign RD_WRITE_ENABLE_OUT       = rd_write_enable_p1;

endmodule

// File: tb/tb_execution_stage.sv
// Scoreboard bench for execution_stage: directed cases plus randomized traffic
// checked against a behavioural model of the EX/MEM register contents.
module tb_execution_stage;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] alu;
    logic        br;
    logic [2:0]  ld;
    logic [1:0]  st;
    logic [31:0] sd;
    logic        wb;
    logic        we;
  } regs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] pc = '0;
  logic [4:0]  rd_in = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [31:0] imm = '0;
  logic [4:0]  op = '0;
  logic        sel1 = 1'b0;
  logic        sel2 = 1'b0;
  logic [2:0]  ld_in = '0;
  logic [1:0]  st_in = '0;
  logic        wb_in = 1'b0;
  logic        we_in = 1'b0;

  logic [4:0]  rd_out;
  logic [31:0] alu_out;
  logic        br_out;
  logic [2:0]  ld_out;
  logic [1:0]  st_out;
  logic [31:0] sd_out;
  logic        wb_out;
  logic        we_out;

  regs_t expq[$];
  regs_t model_state = '0;
  int    errors = 0;
  int    checks = 0;
  int    cycle = 0;

  execution_stage dut (
    .CLK(clk), .RST(rst),
    .STALL_EXECUTION_STAGE(stall), .CLEAR_EXECUTION_STAGE(clear),
    .PC_IN(pc), .RD_ADDRESS_IN(rd_in), .RS1_DATA(rs1), .RS2_DATA(rs2),
    .IMM_DATA(imm), .ALU_INSTRUCTION(op),
    .ALU_INPUT_1_SELECT(sel1), .ALU_INPUT_2_SELECT(sel2),
    .DATA_CACHE_LOAD_IN(ld_in), .DATA_CACHE_STORE_IN(st_in),
    .WRITE_BACK_MUX_SELECT_IN(wb_in), .RD_WRITE_ENABLE_IN(we_in),
    .RD_ADDRESS_OUT(rd_out), .ALU_OUT(alu_out), .BRANCH_TAKEN(br_out),
    .DATA_CACHE_LOAD_OUT(ld_out), .DATA_CACHE_STORE_OUT(st_out),
    .DATA_CACHE_STORE_DATA(sd_out), .WRITE_BACK_MUX_SELECT_OUT(wb_out),
    .RD_WRITE_ENABLE_OUT(we_out)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic from the opcode table.
  function automatic logic [31:0] ref_alu(input logic [4:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    logic [31:0] fill;
    sh = b % 32;
    case (o)
      5'd1:  return a + b;
      5'd2:  return a + (~b + 32'd1);
      5'd3:  return a * (32'd1 << sh);
      5'd4:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      5'd5:  return (a < b) ? 32'd1 : 32'd0;
      5'd6:  return a ^ b;
      5'd7:  return a / (32'd1 << sh);
      5'd8: begin
        fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
        return (a >> sh) | fill;
      end
      5'd9:  return a | b;
      5'd10: return a & b;
      5'd17: return (a + b) - ((a + b) % 2);
      5'd18: return b;
      default: return (o >= 5'd11 && o <= 5'd16) ? a + b : 32'd0;
    endcase
  endfunction

  function automatic logic ref_branch(input logic [4:0] o, input logic [31:0] x,
                                      input logic [31:0] y);
    logic lt_s;
    lt_s = (x ^ 32'h8000_0000) < (y ^ 32'h8000_0000);
    case (o)
      5'd11: return x == y;
      5'd12: return x != y;
      5'd13: return lt_s;
      5'd14: return !lt_s;
      5'd15: return x < y;
      5'd16: return x >= y;
      5'd17: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Apply current inputs for one edge; expected register content is queued
  // after the edge so the monitor picks it up on the following falling edge.
  task automatic step();
    regs_t nxt;
    logic [31:0] a, b;
    a = sel1 ? pc : rs1;
    b = sel2 ? imm : rs2;
    if (rst || clear) nxt = '0;
    else if (stall) nxt = model_state;
    else begin
      nxt.rd  = rd_in;
      nxt.alu = ref_alu(op, a, b);
      nxt.br  = ref_branch(op, rs1, rs2);
      nxt.ld  = ld_in;
      nxt.st  = st_in;
      nxt.sd  = rs2;
      nxt.wb  = wb_in;
      nxt.we  = we_in;
    end
    model_state = nxt;
    @(posedge clk);
    #1;
    expq.push_back(nxt);
  endtask

  task automatic set_op(input logic [4:0] o, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] im, input logic [31:0] p,
                        input logic s1, input logic s2);
    op = o; rs1 = r1; rs2 = r2; imm = im; pc = p; sel1 = s1; sel2 = s2;
    rd_in = 5'($urandom); ld_in = 3'($urandom); st_in = 2'($urandom);
    wb_in = 1'($urandom); we_in = 1'($urandom);
  endtask

  always @(negedge clk) begin
    regs_t act;
    regs_t req;
    cycle++;
    if (expq.size() > 0) begin
      req = expq.pop_front();
      act = '{rd: rd_out, alu: alu_out, br: br_out, ld: ld_out, st: st_out,
              sd: sd_out, wb: wb_out, we: we_out};
      checks++;
      if (act !== req) begin
        errors++;
        $display("FAIL ex_mem_regs cycle %0d: actual rd=%0d alu=%h br=%b ld=%0d st=%0d sd=%h wb=%b we=%b, required rd=%0d alu=%h br=%b ld=%0d st=%0d sd=%h wb=%b we=%b",
                 cycle, act.rd, act.alu, act.br, act.ld, act.st, act.sd, act.wb, act.we,
                 req.rd, req.alu, req.br, req.ld, req.st, req.sd, req.wb, req.we);
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: stimulus did not complete within 200000 time units, %0d checks done",
             checks);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2;
    rst = 1'b1; set_op(5'd1, 32'h1234, 32'h55, 32'h7, 32'h40, 1'b0, 1'b0); step();
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (rd_out !== 5'd0 || alu_out !== 32'd0 || br_out !== 1'b0 || ld_out !== 3'd0 ||
        st_out !== 2'd0 || sd_out !== 32'd0 || wb_out !== 1'b0 || we_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: actual rd=%0d alu=%h br=%b ld=%0d st=%0d sd=%h wb=%b we=%b, required all zero",
               rd_out, alu_out, br_out, ld_out, st_out, sd_out, wb_out, we_out);
    end
    set_op(5'd1, 32'd2, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0); step();
    set_op(5'd1, 32'd5, 32'd9, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1); step();
    set_op(5'd4, 32'd5, 32'd9, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1); step();
    set_op(5'd5, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0); step();
    set_op(5'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0); step();
    set_op(5'd11, 32'd7, 32'd7, 32'h20, 32'h100, 1'b1, 1'b1); step();
    set_op(5'd11, 32'd7, 32'd8, 32'h20, 32'h100, 1'b1, 1'b1); step();
    set_op(5'd17, 32'h1001, 32'd3, 32'd4, 32'h0, 1'b0, 1'b1); step();
    set_op(5'd8, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0); step();
    set_op(5'd18, 32'd1, 32'd2, 32'hABCD_E000, 32'd0, 1'b0, 1'b1); step();
    set_op(5'd25, 32'd3, 32'd3, 32'd3, 32'd3, 1'b0, 1'b0); step();
    // Stall holds a loaded ADD result across changing inputs.
    set_op(5'd1, 32'd2, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0); step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_op(5'($urandom), $urandom, $urandom, $urandom, $urandom, 1'b0, 1'b0); step();
    end
    stall = 1'b0;
    set_op(5'd2, 32'd10, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0); step();
    // Clear beats stall.
    stall = 1'b1; clear = 1'b1;
    set_op(5'd1, 32'd2, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0);
    we_in = 1'b1; rd_in = 5'd5; step();
    stall = 1'b0; clear = 1'b0;
    set_op(5'd3, 32'h1, 32'd31, 32'd0, 32'd0, 1'b0, 1'b0); step();
    // Reset while stalled clears the register.
    stall = 1'b1; rst = 1'b1; step();
    rst = 1'b0; step();
    stall = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 99) < 2);
      clear = ($urandom_range(0, 99) < 5);
      stall = ($urandom_range(0, 99) < 15);
      set_op(5'($urandom_range(0, 31)), $urandom, $urandom, $urandom, $urandom,
             1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) rs2 = rs1;
      if ($urandom_range(0, 3) == 0) rs2[31] = ~rs1[31];
      step();
    end
    rst = 1'b0; clear = 1'b0; stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual %0d expectations still pending, required 0",
               expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/execution_stage.md
Name: execution_stage

Overview:
- Execute (EX) stage of the 5-stage RV32I pipeline, between decode and memory access.
- Selects the ALU operands, performs the ALU operation, and evaluates branch/jump conditions.
- Registers the result and the forwarded control fields into the EX/MEM pipeline register.
- Supports stall (hold) and clear (bubble insertion) from the hazard unit.

Parameters:
- None. Data width is fixed at 32 bits and register address width at 5 bits.

Ports:
CLK  in  1  rising-edge clock
RST  in  1  synchronous, active-high reset
STALL_EXECUTION_STAGE  in  1  hold all output registers
CLEAR_EXECUTION_STAGE  in  1  load a bubble (all outputs zero) on next edge
PC_IN  in  32  PC of the instruction in EX
RD_ADDRESS_IN  in  5  destination register
RS1_DATA  in  32  source operand 1 (already forwarded)
RS2_DATA  in  32  source operand 2 (already forwarded)
IMM_DATA  in  32  sign-extended immediate
ALU_INSTRUCTION  in  5  operation code (see Behaviour)
ALU_INPUT_1_SELECT  in  1  0: A=RS1_DATA, 1: A=PC_IN
ALU_INPUT_2_SELECT  in  1  0: B=RS2_DATA, 1: B=IMM_DATA
DATA_CACHE_LOAD_IN  in  3  load type, passed through
DATA_CACHE_STORE_IN  in  2  store type, passed through
WRITE_BACK_MUX_SELECT_IN  in  1  passed through
RD_WRITE_ENABLE_IN  in  1  passed through
RD_ADDRESS_OUT  out  5  registered RD_ADDRESS_IN
ALU_OUT  out  32  registered ALU result / branch target
BRANCH_TAKEN  out  1  registered branch/jump decision
DATA_CACHE_LOAD_OUT  out  3  registered
DATA_CACHE_STORE_OUT  out  2  registered
DATA_CACHE_STORE_DATA  out  32  registered RS2_DATA
WRITE_BACK_MUX_SELECT_OUT  out  1  registered
RD_WRITE_ENABLE_OUT  out  1  registered

Behaviour:
- The ALU is combinational on operands A and B. Every output is a flop updated on the CLK rising edge, giving 1-cycle latency.
- Register update priority: RST > CLEAR > STALL > normal load.
  - RST=1 or CLEAR=1: all outputs become 0.
  - STALL=1 (no clear): all outputs hold their values.
  - Otherwise: load the new values.
- ALU_INSTRUCTION codes. Shifts use B[4:0]. "Signed" means two's-complement.
  - 00000 NOP: 0
  - 00001 ADD: A+B (mod 2^32)
  - 00010 SUB: A-B
  - 00011 SLL
  - 00100 SLT: signed compare, result 1/0
  - 00101 SLTU: unsigned compare, result 1/0
  - 00110 XOR
  - 00111 SRL
  - 01000 SRA: arithmetic shift
  - 01001 OR
  - 01010 AND
  - 01011–10000 BEQ, BNE, BLT, BGE, BLTU, BGEU: result = A+B (target). Condition compares RS1_DATA vs RS2_DATA directly, independent of the select inputs (BLT/BGE signed, BLTU/BGEU unsigned). BRANCH_TAKEN = condition.
  - 10001 JUMP: result = (A+B) & ~1; BRANCH_TAKEN = 1.
  - 10010 PASS_B: result = B (LUI).
  - 10011–11111 reserved: result 0, BRANCH_TAKEN 0.
- BRANCH_TAKEN is 0 for every non-branch, non-jump code.
- Overflow wraps silently. There are no exceptions.
- Pass-through fields are copied unchanged into the register, including when RD_WRITE_ENABLE_IN=0.
- CLEAR and STALL asserted together: CLEAR wins.
- A reset asserted mid-stall clears the registers.

Test Plan:
- RST=1 for 1 edge → all outputs 0. Then RS1=2, RS2=1, ADD, sel1=0, sel2=0 → after the next edge ALU_OUT=3, BRANCH_TAKEN=0, DATA_CACHE_STORE_DATA=1.
- RS1=5, sel2=1, IMM=0xFFFFFFFF, ADD → ALU_OUT=4. Same operands with SLT → 0. RS1=0xFFFFFFFF, RS2=1, SLTU → 0; SLT → 1.
- BEQ with RS1=RS2=7, PC=0x100, IMM=0x20, sel1=1, sel2=1 → ALU_OUT=0x120, BRANCH_TAKEN=1. Change RS2=8 → BRANCH_TAKEN=0.
- JUMP with RS1=0x1001, IMM=4, sel1=0, sel2=1 → ALU_OUT=0x1004, BRANCH_TAKEN=1. SRA with RS1=0x80000000, RS2=4 → 0xF8000000.
- Load ADD result 3, then STALL=1 with new inputs for 3 edges → outputs stay 3. Release the stall → outputs update.
- CLEAR=1 together with STALL=1, RD_WRITE_ENABLE_IN=1, RD_ADDRESS_IN=5 → next edge RD_WRITE_ENABLE_OUT=0, RD_ADDRESS_OUT=0, ALU_OUT=0.
